// File: rtl/cacheline_adaptor.sv
// Converts a single-cycle cache-line request into a BEATS-long memory burst
// and back; every output is a register.
module cacheline_adaptor #(
  parameter int unsigned LINE_W  = 256,
  parameter int unsigned BURST_W = 64,
  parameter int unsigned BEATS   = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [LINE_W-1:0]  line_i,
  output logic [LINE_W-1:0]  line_o,
  input  logic [31:0]        address_i,
  input  logic               read_i,
  input  logic               write_i,
  output logic               resp_o,
  input  logic [BURST_W-1:0] burst_i,
  output logic [BURST_W-1:0] burst_o,
  output logic [31:0]        address_o,
  output logic               read_o,
  output logic               write_o,
  input  logic               resp_i
);

  localparam int unsigned CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [LINE_W-1:0]  line_q, line_d;
  logic [LINE_W-1:0]  wline_q, wline_d;
  logic [31:0]        addr_q, addr_d;
  logic [BURST_W-1:0] burst_q, burst_d;
  logic               read_q, read_d;
  logic               write_q, write_d;
  logic               resp_q, resp_d;
  logic               last_beat;

  assign last_beat = (count_q == CNT_W'(BEATS - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (read_i)       state_d = READ;
        else if (write_i) state_d = WRITE;
      end
      READ:    if (resp_i && last_beat) state_d = DONE;
      WRITE:   if (resp_i && last_beat) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    count_d = count_q;
    line_d  = line_q;
    wline_d = wline_q;
    addr_d  = addr_q;
    burst_d = burst_q;
    read_d  = read_q;
    write_d = write_q;
    resp_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (read_i) begin
          addr_d  = address_i & ~32'h0000_001F;
          count_d = '0;
          read_d  = 1'b1;
        end else if (write_i) begin
          addr_d  = address_i & ~32'h0000_001F;
          wline_d = line_i;
          burst_d = line_i[BURST_W-1:0];
          count_d = '0;
          write_d = 1'b1;
        end
      end
      READ: begin
        if (resp_i) begin
          for (int unsigned i = 0; i < BEATS; i++) begin
            if (count_q == CNT_W'(i)) line_d[i*BURST_W +: BURST_W] = burst_i;
          end
          if (last_beat) begin
            read_d = 1'b0;
            resp_d = 1'b1;
          end else begin
            count_d = count_q + CNT_W'(1);
          end
        end
      end
      WRITE: begin
        if (resp_i) begin
          if (last_beat) begin
            write_d = 1'b0;
            resp_d  = 1'b1;
          end else begin
            count_d = count_q + CNT_W'(1);
            // Preload the next beat so burst_o stays a pure register output.
            for (int unsigned i = 0; i < BEATS; i++) begin
              if (count_q + CNT_W'(1) == CNT_W'(i)) burst_d = wline_q[i*BURST_W +: BURST_W];
            end
          end
        end
      end
      DONE:    resp_d = 1'b0;
      default: resp_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
      line_q  <= '0;
      wline_q <= '0;
      addr_q  <= '0;
      burst_q <= '0;
      read_q  <= 1'b0;
      write_q <= 1'b0;
      resp_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      line_q  <= line_d;
      wline_q <= wline_d;
      addr_q  <= addr_d;
      burst_q <= burst_d;
      read_q  <= read_d;
      write_q <= write_d;
      resp_q  <= resp_d;
    end
  end

  assign line_o    = line_q;
  assign address_o = addr_q;
  assign burst_o   = burst_q;
  assign read_o    = read_q;
  assign write_o   = write_q;
  assign resp_o    = resp_q;

endmodule

// File: tb/tb_cacheline_adaptor.sv
// Randomized bench for cacheline_adaptor: a transaction-level memory/requester
// model predicts line contents, beat order, alignment and completion latency.
module tb_cacheline_adaptor;

  localparam int unsigned LINE_W  = 256;
  localparam int unsigned BURST_W = 64;
  localparam int unsigned BEATS   = 4;

  logic               clk = 1'b0;
  logic               rst;
  logic [LINE_W-1:0]  line_i;
  logic [LINE_W-1:0]  line_o;
  logic [31:0]        address_i;
  logic               read_i;
  logic               write_i;
  logic               resp_o;
  logic [BURST_W-1:0] burst_i;
  logic [BURST_W-1:0] burst_o;
  logic [31:0]        address_o;
  logic               read_o;
  logic               write_o;
  logic               resp_i;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  logic [LINE_W-1:0] exp_line;

  cacheline_adaptor #(.LINE_W(LINE_W), .BURST_W(BURST_W), .BEATS(BEATS)) dut (
    .clk(clk), .rst(rst), .line_i(line_i), .line_o(line_o),
    .address_i(address_i), .read_i(read_i), .write_i(write_i), .resp_o(resp_o),
    .burst_i(burst_i), .burst_o(burst_o), .address_o(address_o),
    .read_o(read_o), .write_o(write_o), .resp_i(resp_i)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [LINE_W-1:0] rand_line();
    logic [LINE_W-1:0] v;
    for (int i = 0; i < LINE_W / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic check_idle_outputs(input string tag);
    check_eq({tag, "_read_o"},  read_o,  1'b0);
    check_eq({tag, "_write_o"}, write_o, 1'b0);
    check_eq({tag, "_resp_o"},  resp_o,  1'b0);
    check_eq({tag, "_line_o"},  line_o,  exp_line);
  endtask

  task automatic idle_noise(input int unsigned n);
    read_i  = 1'b0;
    write_i = 1'b0;
    repeat (n) begin
      resp_i  = 1'($urandom);
      burst_i = {$urandom, $urandom};
      tick();
      check_idle_outputs("idle");
    end
    resp_i = 1'b0;
  endtask

  task automatic do_read(input logic [31:0] addr, input logic [LINE_W-1:0] data,
                         input int unsigned gap_lo, input int unsigned gap_hi,
                         input bit both, input bit hold);
    int unsigned cyc, gaps, g;
    logic [31:0] al;
    al = addr & 32'hFFFF_FFE0;
    gaps = 0;
    address_i = addr; read_i = 1'b1; write_i = both; line_i = rand_line(); resp_i = 1'b0;
    tick(); cyc = 1;
    check_eq("rd_read_o", read_o, 1'b1);
    check_eq("rd_write_o", write_o, 1'b0);
    check_eq("rd_addr", address_o, al);
    for (int k = 0; k < BEATS; k++) begin
      g = $urandom_range(gap_hi, gap_lo);
      gaps += g;
      repeat (g) begin
        resp_i = 1'b0; burst_i = {$urandom, $urandom}; address_i = $urandom;
        tick(); cyc++;
        check_eq("rd_stall_read_o", read_o, 1'b1);
        check_eq("rd_stall_resp_o", resp_o, 1'b0);
        check_eq("rd_stall_addr", address_o, al);
      end
      resp_i = 1'b1; burst_i = data[k*BURST_W +: BURST_W];
      tick(); cyc++;
      if (k < BEATS - 1) begin
        check_eq("rd_beat_resp_o", resp_o, 1'b0);
        check_eq("rd_beat_read_o", read_o, 1'b1);
      end
    end
    resp_i = 1'b0;
    exp_line = data;
    check_eq("rd_resp_o", resp_o, 1'b1);
    check_eq("rd_done_read_o", read_o, 1'b0);
    check_eq("rd_line", line_o, exp_line);
    check_eq("rd_latency", cyc, 1 + BEATS + gaps);
    if (!hold) begin read_i = 1'b0; write_i = 1'b0; end
    tick();
    read_i = 1'b0; write_i = 1'b0;
    check_idle_outputs("rd_after");
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [LINE_W-1:0] data,
                          input int unsigned gap_lo, input int unsigned gap_hi, input bit hold);
    int unsigned cyc, gaps, g;
    logic [31:0] al;
    al = addr & 32'hFFFF_FFE0;
    gaps = 0;
    address_i = addr; read_i = 1'b0; write_i = 1'b1; line_i = data; resp_i = 1'b0;
    tick(); cyc = 1;
    line_i = rand_line();
    check_eq("wr_write_o", write_o, 1'b1);
    check_eq("wr_read_o", read_o, 1'b0);
    check_eq("wr_addr", address_o, al);
    for (int k = 0; k < BEATS; k++) begin
      g = $urandom_range(gap_hi, gap_lo);
      gaps += g;
      repeat (g) begin
        resp_i = 1'b0; address_i = $urandom;
        tick(); cyc++;
        check_eq("wr_stall_burst", burst_o, data[k*BURST_W +: BURST_W]);
        check_eq("wr_stall_write_o", write_o, 1'b1);
        check_eq("wr_stall_resp_o", resp_o, 1'b0);
        check_eq("wr_stall_addr", address_o, al);
      end
      check_eq("wr_beat", burst_o, data[k*BURST_W +: BURST_W]);
      resp_i = 1'b1;
      tick(); cyc++;
      if (k < BEATS - 1) check_eq("wr_beat_resp_o", resp_o, 1'b0);
    end
    resp_i = 1'b0;
    check_eq("wr_resp_o", resp_o, 1'b1);
    check_eq("wr_done_write_o", write_o, 1'b0);
    check_eq("wr_line_kept", line_o, exp_line);
    check_eq("wr_latency", cyc, 1 + BEATS + gaps);
    if (!hold) write_i = 1'b0;
    tick();
    write_i = 1'b0;
    check_idle_outputs("wr_after");
  endtask

  task automatic reset_mid(input bit is_write);
    address_i = $urandom; read_i = !is_write; write_i = is_write;
    line_i = rand_line(); resp_i = 1'b0;
    tick();
    resp_i = 1'b1; burst_i = {$urandom, $urandom};
    tick();
    burst_i = {$urandom, $urandom};
    tick();
    resp_i = 1'b0;
    #2 rst = 1'b1;
    #1;
    exp_line = '0;
    check_eq("rst_read_o", read_o, 1'b0);
    check_eq("rst_write_o", write_o, 1'b0);
    check_eq("rst_resp_o", resp_o, 1'b0);
    check_eq("rst_addr", address_o, 32'h0);
    check_eq("rst_burst", burst_o, 64'h0);
    check_eq("rst_line", line_o, exp_line);
    read_i = 1'b0; write_i = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    check_idle_outputs("post_rst");
  endtask

  initial begin
    logic [LINE_W-1:0] d;
    rst = 1'b1; line_i = '0; address_i = '0; read_i = 1'b0; write_i = 1'b0;
    burst_i = '0; resp_i = 1'b0; exp_line = '0;
    tick(); tick();
    check_eq("reset_addr", address_o, 32'h0);
    check_eq("reset_burst", burst_o, 64'h0);
    check_idle_outputs("reset");
    rst = 1'b0;
    tick();

    d = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
         64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
    do_read(32'h0000_1234, d, 0, 0, 1'b0, 1'b0);
    d = {64'hDDDD_DDDD_DDDD_DDDD, 64'hCCCC_CCCC_CCCC_CCCC,
         64'hBBBB_BBBB_BBBB_BBBB, 64'hAAAA_AAAA_AAAA_AAAA};
    do_write(32'h0000_ABCD, d, 0, 0, 1'b0);
    do_read($urandom, rand_line(), 3, 3, 1'b0, 1'b0);
    do_write($urandom, rand_line(), 3, 3, 1'b0);
    do_read($urandom, rand_line(), 0, 1, 1'b1, 1'b0);
    idle_noise(3);

    reset_mid(1'b0);
    do_read($urandom, rand_line(), 0, 0, 1'b0, 1'b0);
    reset_mid(1'b1);
    do_write($urandom, rand_line(), 0, 1, 1'b0);

    for (int t = 0; t < 40; t++) begin
      if ($urandom_range(1, 0) == 0)
        do_read($urandom, rand_line(), 0, $urandom_range(3, 0), 1'($urandom), 1'($urandom));
      else
        do_write($urandom, rand_line(), 0, $urandom_range(3, 0), 1'($urandom));
      idle_noise($urandom_range(2, 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/cacheline_adaptor.md
CACHELINE_ADAPTOR -- requirements
Module: cacheline_adaptor

Interface
REQ-001 SHALL have parameter LINE_W, default 256, cache line width in bits.
REQ-002 SHALL have parameter BURST_W, default 64, memory beat width in bits.
REQ-003 SHALL have parameter BEATS, default 4 (LINE_W/BURST_W), beats per line transfer.
REQ-004 clk  in  1  single clock; all state updates on posedge.
REQ-005 rst  in  1  reset; asynchronous, active-high.
REQ-006 line_i  in  LINE_W  write data from arbiter.
REQ-007 line_o  out  LINE_W  read data to arbiter.
REQ-008 address_i  in  32  line address from arbiter.
REQ-009 read_i  in  1  line read request; held until resp_o.
REQ-010 write_i  in  1  line write request; held until resp_o.
REQ-011 resp_o  out  1  one-cycle transfer-complete pulse.
REQ-012 burst_i  in  BURST_W  read beat from memory.
REQ-013 burst_o  out  BURST_W  write beat to memory.
REQ-014 address_o  out  32  line-aligned memory address.
REQ-015 read_o  out  1  burst read request.
REQ-016 write_o  out  1  burst write request.
REQ-017 resp_i  in  1  memory beat valid/accepted, one beat per high cycle.

Function
REQ-018 SHALL implement FSM states IDLE, READ, WRITE, DONE; all outputs driven from registers.
REQ-019 IDLE: read_i high -> latch address_i with bits [4:0] cleared into address_o, beat count=0, assert read_o, go READ.
REQ-020 IDLE: write_i high and read_i low -> latch line_i and aligned address, count=0, assert write_o, go WRITE.
REQ-021 Both read_i and write_i high in IDLE -> read wins; write_i ignored.
REQ-022 READ: each cycle resp_i=1 -> store burst_i into line_o bits [count*BURST_W +: BURST_W], count++.
REQ-023 READ: on beat BEATS-1 accepted -> deassert read_o next cycle, go DONE; resp_i while IDLE/DONE ignored.
REQ-024 WRITE: burst_o SHALL present beat[count] of latched line; on resp_i=1 count++; after beat BEATS-1 accepted deassert write_o, go DONE.
REQ-025 resp_i low in READ/WRITE -> hold state, count, request and burst_o unchanged (unbounded wait).
REQ-026 DONE: resp_o=1 for exactly one cycle, then IDLE; new request not sampled in DONE.
REQ-027 line_o SHALL stay stable from DONE until the next read's first beat; writes never modify line_o.
REQ-028 address_o SHALL remain constant for whole transfer regardless of address_i changes.
REQ-029 Latency: request seen cycle 0 -> read_o/write_o high cycle 1; with resp_i held high from cycle 1, resp_o high cycle 1+BEATS.
REQ-030 count SHALL be ceil(log2(BEATS)) bits; no wrap beyond BEATS-1 (FSM exits first).

Reset
REQ-031 rst high SHALL immediately force IDLE, count=0, resp_o=0, read_o=0, write_o=0, address_o=0, burst_o=0, line_o=0, including mid-transfer.
REQ-032 After rst deasserts, first posedge with read_i/write_i high SHALL start a new transfer per REQ-019/020.

Verification
REQ-033 Read: address_i=0x0000_1234, read_i=1, resp_i=1 beats 0x11..,0x22..,0x33..,0x44.. -> address_o=0x0000_1220, line_o={0x44..,0x33..,0x22..,0x11..}, resp_o one cycle at cycle 5.
REQ-034 Write: line_i=256'hDDDD..CCCC..BBBB..AAAA.., write_i=1 -> burst_o AAAA.., BBBB.., CCCC.., DDDD.. in order, one per resp_i, resp_o after 4th.
REQ-035 Stall: resp_i gaps of 3 cycles between beats -> count/burst_o/read_o hold; correct line, resp_o once.
REQ-036 Simultaneous read_i=1, write_i=1 in IDLE -> read_o=1, write_o=0.
REQ-037 Reset mid-read after 2 beats -> all outputs 0 asynchronously; subsequent read completes correctly with 4 fresh beats.
REQ-038 Back-to-back: requester drops read_i after resp_o, raises write_i next cycle -> write_o asserted one cycle after IDLE sample, no spurious second read.
